// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - state_e   : controller FSM encoding (RUN=00, MEM_WAIT=01, FLUSH=10)
//   - FWD_*     : EX operand-select codes driven on fwd_a_o / fwd_b_o
//   - fwd_sel() : forwarding priority for one EX source register
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_FLUSH    = 2'b10
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from MEM-stage result
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from WB-stage result

  // MEM wins over WB because it holds the younger write to the same register.
  // x0 is hard-wired zero, so a write "to" x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] mem_rd,
    input logic       mem_we,
    input logic [4:0] wb_rd,
    input logic       wb_we
  );
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      return FWD_MEM;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_fwd.sv
// forwarding_unit: purely combinational EX operand-select generation.
// Ports:
//   ex_rs1_i, ex_rs2_i   : source registers of the instruction in EX
//   mem_rd_i, mem_we_i   : MEM-stage destination and write flag
//   wb_rd_i,  wb_we_i    : WB-stage destination and write flag
//   fwd_a_o,  fwd_b_o    : operand selects (FWD_RF / FWD_MEM / FWD_WB)
module forwarding_unit
  import pipeline_hazard_controller_pkg::*;
(
  input  logic [4:0] ex_rs1_i,
  input  logic [4:0] ex_rs2_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_we_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_we_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  assign fwd_a_o = fwd_sel(ex_rs1_i, mem_rd_i, mem_we_i, wb_rd_i, wb_we_i);
  assign fwd_b_o = fwd_sel(ex_rs2_i, mem_rd_i, mem_we_i, wb_rd_i, wb_we_i);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall / flush / forwarding control for a
// 5-stage in-order pipeline (IF, ID, EX, MEM, WB).
// Ports:
//   clk_i, reset_i (async, active-low)
//   id_rs1_i/id_rs2_i, ex_rs1_i/ex_rs2_i/ex_rd_i, ex_mem_read_i, ex_reg_write_i
//   mem_rd_i/mem_reg_write_i, wb_rd_i/wb_reg_write_i : hazard sources
//   branch_taken_i                 : control transfer resolved taken in EX
//   dmem_req_i, dmem_ack_i         : MEM-stage data-memory handshake
//   pc_en_o .. memwb_en_o          : stage-register load enables
//   ifid/idex/memwb_flush_o        : load a bubble into that register
//   fwd_a_o, fwd_b_o               : EX operand selects
//   stall_cnt_o                    : saturating count of cycles with pc_en_o=0
//   state_o                        : current FSM state (debug)
//
// Data-memory handshake: the MEM stage raises dmem_req_i for an access and
// the memory raises dmem_ack_i in the cycle the access completes. A cycle
// with req=1 and ack=0 freezes the whole pipeline; the first cycle with
// ack=1 releases it and the pipeline advances that same cycle.
//
// All control outputs are combinational from state and inputs so that the
// stage registers see them in the same cycle the hazard appears.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [4:0]             id_rs1_i,
  input  logic [4:0]             id_rs2_i,
  input  logic [4:0]             ex_rs1_i,
  input  logic [4:0]             ex_rs2_i,
  input  logic [4:0]             ex_rd_i,
  input  logic                   ex_mem_read_i,
  input  logic                   ex_reg_write_i,
  input  logic [4:0]             mem_rd_i,
  input  logic                   mem_reg_write_i,
  input  logic [4:0]             wb_rd_i,
  input  logic                   wb_reg_write_i,
  input  logic                   branch_taken_i,
  input  logic                   dmem_req_i,
  input  logic                   dmem_ack_i,
  output logic                   pc_en_o,
  output logic                   ifid_en_o,
  output logic                   idex_en_o,
  output logic                   exmem_en_o,
  output logic                   memwb_en_o,
  output logic                   ifid_flush_o,
  output logic                   idex_flush_o,
  output logic                   memwb_flush_o,
  output logic [1:0]             fwd_a_o,
  output logic [1:0]             fwd_b_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic [1:0]             state_o
);

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  state_e                   r_state;
  logic [STALL_CNT_W-1:0]   r_stall_cnt;
  state_e                   w_state_nxt;
  logic                     w_freeze;
  logic                     w_load_use;
  logic                     w_lu_allowed;
  logic [1:0]               w_fwd_a;
  logic [1:0]               w_fwd_b;

  // ex_reg_write_i is implied for a load; the load-use test keys on the
  // load flag alone, so the write flag is not needed here.
  logic w_unused;
  assign w_unused = ex_reg_write_i;

  // In MEM_WAIT only the ack matters (req is assumed still held); elsewhere a
  // new freeze starts on req without ack.
  assign w_freeze = (r_state == ST_MEM_WAIT) ? !dmem_ack_i
                                             : (dmem_req_i && !dmem_ack_i);

  assign w_load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                      ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

  // After a taken branch ID holds a bubble, so its register fields are stale.
  assign w_lu_allowed = (r_state != ST_FLUSH);

  forwarding_unit u_fwd (
    .ex_rs1_i (ex_rs1_i),
    .ex_rs2_i (ex_rs2_i),
    .mem_rd_i (mem_rd_i),
    .mem_we_i (mem_reg_write_i),
    .wb_rd_i  (wb_rd_i),
    .wb_we_i  (wb_reg_write_i),
    .fwd_a_o  (w_fwd_a),
    .fwd_b_o  (w_fwd_b)
  );

  // Priority: mem freeze > taken branch > load-use. On the ack cycle out of
  // MEM_WAIT the pipeline advances, so a branch held in EX during the freeze
  // is flushed here.
  always_comb begin
    pc_en_o       = 1'b1;
    ifid_en_o     = 1'b1;
    idex_en_o     = 1'b1;
    exmem_en_o    = 1'b1;
    memwb_en_o    = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    memwb_flush_o = 1'b0;
    fwd_a_o       = w_fwd_a;
    fwd_b_o       = w_fwd_b;
    w_state_nxt   = ST_RUN;
    if (!reset_i) begin
      pc_en_o       = 1'b0;
      ifid_en_o     = 1'b0;
      idex_en_o     = 1'b0;
      exmem_en_o    = 1'b0;
      memwb_en_o    = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      memwb_flush_o = 1'b1;
      fwd_a_o       = FWD_RF;
      fwd_b_o       = FWD_RF;
    end else if (w_freeze) begin
      // Hold every stage; WB retires nothing while MEM is stuck.
      pc_en_o       = 1'b0;
      ifid_en_o     = 1'b0;
      idex_en_o     = 1'b0;
      exmem_en_o    = 1'b0;
      memwb_en_o    = 1'b0;
      memwb_flush_o = 1'b1;
      w_state_nxt   = ST_MEM_WAIT;
    end else if (branch_taken_i) begin
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      w_state_nxt   = ST_FLUSH;
    end else if (w_load_use && w_lu_allowed) begin
      // Hold IF/ID one cycle and insert a single bubble into EX.
      pc_en_o       = 1'b0;
      ifid_en_o     = 1'b0;
      idex_flush_o  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!pc_en_o && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign state_o     = r_state;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller. Inputs change on the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
// The counter width is reduced to 4 bits so saturation is reachable quickly.
module tb_pipeline_hazard_controller;

  localparam int CW = 4;

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, memwb_flush}
  localparam logic [7:0] CTL_RST = 8'b00000_111;
  localparam logic [7:0] CTL_RUN = 8'b11111_000;
  localparam logic [7:0] CTL_LU  = 8'b00111_010;
  localparam logic [7:0] CTL_BR  = 8'b11111_110;
  localparam logic [7:0] CTL_FRZ = 8'b00000_001;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [4:0]    id_rs1_i, id_rs2_i, ex_rs1_i, ex_rs2_i, ex_rd_i;
  logic          ex_mem_read_i, ex_reg_write_i;
  logic [4:0]    mem_rd_i, wb_rd_i;
  logic          mem_reg_write_i, wb_reg_write_i;
  logic          branch_taken_i, dmem_req_i, dmem_ack_i;
  logic          pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o;
  logic          ifid_flush_o, idex_flush_o, memwb_flush_o;
  logic [1:0]    fwd_a_o, fwd_b_o, state_o;
  logic [CW-1:0] stall_cnt_o;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  pipeline_hazard_controller #(.STALL_CNT_W(CW)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .id_rs1_i        (id_rs1_i),
    .id_rs2_i        (id_rs2_i),
    .ex_rs1_i        (ex_rs1_i),
    .ex_rs2_i        (ex_rs2_i),
    .ex_rd_i         (ex_rd_i),
    .ex_mem_read_i   (ex_mem_read_i),
    .ex_reg_write_i  (ex_reg_write_i),
    .mem_rd_i        (mem_rd_i),
    .mem_reg_write_i (mem_reg_write_i),
    .wb_rd_i         (wb_rd_i),
    .wb_reg_write_i  (wb_reg_write_i),
    .branch_taken_i  (branch_taken_i),
    .dmem_req_i      (dmem_req_i),
    .dmem_ack_i      (dmem_ack_i),
    .pc_en_o         (pc_en_o),
    .ifid_en_o       (ifid_en_o),
    .idex_en_o       (idex_en_o),
    .exmem_en_o      (exmem_en_o),
    .memwb_en_o      (memwb_en_o),
    .ifid_flush_o    (ifid_flush_o),
    .idex_flush_o    (idex_flush_o),
    .memwb_flush_o   (memwb_flush_o),
    .fwd_a_o         (fwd_a_o),
    .fwd_b_o         (fwd_b_o),
    .stall_cnt_o     (stall_cnt_o),
    .state_o         (state_o)
  );

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    id_rs1_i = 5'd0; id_rs2_i = 5'd0;
    ex_rs1_i = 5'd0; ex_rs2_i = 5'd0; ex_rd_i = 5'd0;
    ex_mem_read_i = 1'b0; ex_reg_write_i = 1'b0;
    mem_rd_i = 5'd0; mem_reg_write_i = 1'b0;
    wb_rd_i = 5'd0; wb_reg_write_i = 1'b0;
    branch_taken_i = 1'b0; dmem_req_i = 1'b0; dmem_ack_i = 1'b0;
  endtask

  task automatic next_step();
    @(negedge clk_i);
  endtask

  // ---------------- checkers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [7:0] exp);
    chk(tag, {24'd0, pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o,
              ifid_flush_o, idex_flush_o, memwb_flush_o}, {24'd0, exp});
  endtask

  task automatic chk_st(input string tag, input logic [1:0] st, input int cnt);
    chk({tag, "_state"}, {30'd0, state_o}, {30'd0, st});
    chk({tag, "_cnt"}, {28'd0, stall_cnt_o}, cnt);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    clear_inputs();
    reset_i = 1'b0;
    // A forwarding match during reset must still read as 00.
    mem_rd_i = 5'd7; mem_reg_write_i = 1'b1; ex_rs1_i = 5'd7;
    #2;
    chk_ctl("rst_ctl", CTL_RST);
    chk("rst_fwd_a", {30'd0, fwd_a_o}, 32'd0);
    chk_st("rst", 2'b00, 0);

    next_step(); next_step();
    reset_i = 1'b1; clear_inputs(); #1;
    chk_ctl("idle_ctl", CTL_RUN);
    chk_st("idle", 2'b00, 0);

    // Load-use on rs1
    next_step();
    ex_mem_read_i = 1'b1; ex_rd_i = 5'd5; id_rs1_i = 5'd5; #1;
    chk_ctl("lu_rs1_ctl", CTL_LU);
    chk_st("lu_rs1", 2'b00, 0);
    next_step(); clear_inputs(); #1;
    chk_ctl("lu_rs1_after_ctl", CTL_RUN);
    chk_st("lu_rs1_after", 2'b00, 1);

    // Load-use on rs2
    next_step();
    ex_mem_read_i = 1'b1; ex_rd_i = 5'd9; id_rs2_i = 5'd9; id_rs1_i = 5'd3; #1;
    chk_ctl("lu_rs2_ctl", CTL_LU);
    next_step(); clear_inputs(); #1;
    chk_st("lu_rs2_after", 2'b00, 2);

    // Load to x0 never stalls
    next_step();
    ex_mem_read_i = 1'b1; ex_rd_i = 5'd0; id_rs2_i = 5'd0; id_rs1_i = 5'd0; #1;
    chk_ctl("x0_load_ctl", CTL_RUN);
    // Register match without a load does not stall either
    next_step();
    ex_mem_read_i = 1'b0; ex_rd_i = 5'd6; id_rs1_i = 5'd6; #1;
    chk_ctl("no_load_ctl", CTL_RUN);
    next_step(); clear_inputs(); #1;
    chk_st("no_stall", 2'b00, 2);

    // Branch and load-use in the same cycle: branch wins, no stall
    next_step();
    branch_taken_i = 1'b1; ex_mem_read_i = 1'b1; ex_rd_i = 5'd5; id_rs1_i = 5'd5; #1;
    chk_ctl("br_lu_ctl", CTL_BR);
    chk_st("br_lu", 2'b00, 2);
    // FLUSH: same load-use pattern is ignored
    next_step(); branch_taken_i = 1'b0; #1;
    chk_ctl("flush_ctl", CTL_RUN);
    chk_st("flush", 2'b10, 2);
    next_step(); clear_inputs(); #1;
    chk_st("flush_done", 2'b00, 2);

    // Forwarding
    next_step();
    mem_rd_i = 5'd7; wb_rd_i = 5'd7; mem_reg_write_i = 1'b1; wb_reg_write_i = 1'b1;
    ex_rs1_i = 5'd7; ex_rs2_i = 5'd3; #1;
    chk("fwd_mem_a", {30'd0, fwd_a_o}, 32'd2);
    chk("fwd_none_b", {30'd0, fwd_b_o}, 32'd0);
    mem_reg_write_i = 1'b0; ex_rs2_i = 5'd7; #1;
    chk("fwd_wb_a", {30'd0, fwd_a_o}, 32'd1);
    chk("fwd_wb_b", {30'd0, fwd_b_o}, 32'd1);
    mem_rd_i = 5'd0; wb_rd_i = 5'd0; mem_reg_write_i = 1'b1;
    ex_rs1_i = 5'd0; ex_rs2_i = 5'd0; #1;
    chk("fwd_x0_a", {30'd0, fwd_a_o}, 32'd0);
    chk("fwd_x0_b", {30'd0, fwd_b_o}, 32'd0);
    mem_rd_i = 5'd4; wb_rd_i = 5'd7; ex_rs1_i = 5'd7; ex_rs2_i = 5'd4; #1;
    chk("fwd_mix_a", {30'd0, fwd_a_o}, 32'd1);
    chk("fwd_mix_b", {30'd0, fwd_b_o}, 32'd2);

    // Reset asserted while in MEM_WAIT
    next_step(); clear_inputs();
    dmem_req_i = 1'b1; #1;
    chk_ctl("mw_rst_frz_ctl", CTL_FRZ);
    next_step(); #1;
    chk_st("mw_rst_wait", 2'b01, 3);
    mem_rd_i = 5'd7; mem_reg_write_i = 1'b1; ex_rs1_i = 5'd7;
    reset_i = 1'b0; #1;
    chk_ctl("mw_rst_ctl", CTL_RST);
    chk("mw_rst_fwd_a", {30'd0, fwd_a_o}, 32'd0);
    chk_st("mw_rst", 2'b00, 0);
    next_step(); reset_i = 1'b1; clear_inputs(); #1;
    chk_ctl("mw_rel_ctl", CTL_RUN);
    chk_st("mw_rel", 2'b00, 0);

    // Memory wait for three cycles
    next_step(); dmem_req_i = 1'b1; #1;
    chk_ctl("mw1_ctl", CTL_FRZ);
    chk_st("mw1", 2'b00, 0);
    next_step(); #1;
    chk_ctl("mw2_ctl", CTL_FRZ);
    chk_st("mw2", 2'b01, 1);
    next_step(); #1;
    chk_ctl("mw3_ctl", CTL_FRZ);
    chk_st("mw3", 2'b01, 2);
    next_step(); dmem_ack_i = 1'b1; #1;
    chk_ctl("mw_ack_ctl", CTL_RUN);
    chk_st("mw_ack", 2'b01, 3);
    next_step(); clear_inputs(); #1;
    chk_st("mw_done", 2'b00, 3);

    // Branch held in EX during a freeze is taken on the ack cycle
    next_step(); dmem_req_i = 1'b1; branch_taken_i = 1'b1; #1;
    chk_ctl("mw_br_frz_ctl", CTL_FRZ);
    next_step(); dmem_ack_i = 1'b1; #1;
    chk_ctl("mw_br_ack_ctl", CTL_BR);
    chk_st("mw_br_ack", 2'b01, 4);
    next_step(); clear_inputs(); #1;
    chk_st("mw_br_flush", 2'b10, 4);

    // Counter saturation: 20 frozen cycles from 4 on a 4-bit counter
    for (int k = 0; k < 20; k++) begin
      next_step(); dmem_req_i = 1'b1; dmem_ack_i = 1'b0; #1;
      if (k == 10) chk("sat_14", {28'd0, stall_cnt_o}, 32'd14);
      if (k == 11) chk("sat_15", {28'd0, stall_cnt_o}, 32'd15);
    end
    next_step(); dmem_ack_i = 1'b1; #1;
    chk_st("sat_hold", 2'b01, 15);
    next_step(); clear_inputs(); #1;
    chk_st("sat_end", 2'b00, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
